stream_demux_1x2: RTL and testbench
===================================

Name: stream_demux_1x2

Overview:
- Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It is the inverse of the 2:1 word mux.
- It steers each N-bit input beat to output 0 or output 1 according to a per-beat select bit.
- Each output has a one-entry holding register, so the two destinations back-pressure independently.
- Used in the datapath wherever one producer feeds two consumers, for example ALU result vs. store path, and provides per-output beat counters for debug.

Parameters:
- N, 8, data width in bits.
- CNT_W, 8, width of each per-output beat counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the input beat this cycle.
- in_data  input  N  input beat payload.
- in_sel  input  1  destination of the current beat: 0 selects out0, 1 selects out1.
- out0_valid  output  1  out0 holding register full.
- out0_ready  input  1  out0 consumer accepts.
- out0_data  output  N  out0 payload.
- out1_valid  output  1  out1 holding register full.
- out1_ready  input  1  out1 consumer accepts.
- out1_data  output  N  out1 payload.
- cnt0  output  CNT_W  beats accepted toward out0.
- cnt1  output  CNT_W  beats accepted toward out1.

Behaviour:
- Reset: rst_n sampled low at a clock edge clears out0_valid, out1_valid, out0_data, out1_data, cnt0 and cnt1 to 0 on that edge.
  - Any buffered beat is discarded; a reset mid-transfer drops it silently.
  - While rst_n is low, in_ready = 0.
- Slot state: each output k has a holding register (valid_k, data_k) with two states.
  - EMPTY → FULL on a load.
  - FULL → EMPTY when out_k_ready = 1 and no load occurs.
  - FULL → FULL when a drain and a load happen in the same cycle (new data).
  - FULL stays FULL, with data held, while out_k_ready = 0.
- Free condition: free_k = !valid_k || out_k_ready (combinational).
- in_ready = rst_n && (in_sel ? free_1 : free_0). It depends only on in_sel and the selected slot, never on in_valid.
- Accept: when in_valid && in_ready at an edge, data_[in_sel] <= in_data, valid_[in_sel] <= 1, and cnt_[in_sel] increments.
  - The non-selected slot is unaffected.
- Latency: exactly 1 cycle from accept to out_k_valid = 1 with out_k_data = accepted beat.
- Throughput: 1 beat/cycle to a given output while its consumer holds ready = 1, because drain and refill happen in the same cycle.
- Stability: while out_k_valid = 1 and out_k_ready = 0, out_k_data and out_k_valid hold constant.
- Independence: a stalled out1 does not block beats with in_sel = 0, and vice versa.
- Ordering: beat order is preserved per output. No ordering is guaranteed across outputs.
- Counters: wrap modulo 2^CNT_W (255 → 0 at CNT_W = 8). They count accepted input beats, not drained ones.
- No combinational path from in_data to out_k_data. Outputs come directly from registers.
- Inputs sampled only at the rising edge of clk. in_valid with in_ready = 0 is held upstream; no beat is lost or duplicated.

Test Plan:
- Reset: drive rst_n = 0 for 2 cycles with in_valid = 1, in_data = 8'hAA → in_ready = 0, both out valids = 0, cnt0 = cnt1 = 0.
- Basic steer: in_data = 8'hAA with in_sel = 0, then 8'h55 with in_sel = 1, both outputs ready.
  - out0_data = AA is valid one cycle after its accept; out1_data = 55 is valid one cycle after its accept.
  - Ends with cnt0 = 1 and cnt1 = 1.
- Back-pressure: out0_ready = 0, then send 8'hF0 (in_sel = 0) followed by 8'h0F (in_sel = 0).
  - F0 is accepted and out0_valid = 1.
  - in_ready = 0 on the second beat, and out0_data holds F0 for 5 cycles.
  - Raise out0_ready → F0 drains and 0F is accepted in the same cycle, then appears next cycle.
- Independence: out0 stalled and full, then a beat 8'h3C with in_sel = 1 is sent → in_ready = 1 and out1_data = 3C one cycle later; out0 is unchanged.
- Streaming: 16 back-to-back beats 8'h00..8'h0F, in_sel = 0, out0_ready = 1 → in_ready stays 1 and out0_data equals the sequence delayed 1 cycle; cnt0 = 16.
- Reset mid-op and wrap:
  - Assert rst_n = 0 while out1 is full with 8'h77 and stalled → out1_valid = 0 on the next edge.
  - Then 256 beats to out1 → cnt1 wraps to 0.

Source files
------------

// File: rtl/stream_demux_1x2_if.sv
// ---------------------------------------------------------------------------
// stream_demux_1x2_if
//
// Bundles the handshake and data signals of the 1-to-2 stream demultiplexer.
//
// Signals:
//   in_valid / in_ready / in_data / in_sel  upstream beat, handshake, payload
//                                           and destination select
//   out0_valid / out0_ready / out0_data     destination 0 stream
//   out1_valid / out1_ready / out1_data     destination 1 stream
//   cnt0 / cnt1                             per-destination accepted-beat
//                                           debug counters
//
// Modports:
//   slave  - the demux itself (consumes input beats, produces outputs)
//   master - the environment around it (producer plus both consumers)
// ---------------------------------------------------------------------------
interface stream_demux_1x2_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_sel;

    logic             out0_valid;
    logic             out0_ready;
    logic [N-1:0]     out0_data;

    logic             out1_valid;
    logic             out1_ready;
    logic [N-1:0]     out1_data;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_sel,
        output out0_valid,
        input  out0_ready,
        output out0_data,
        output out1_valid,
        input  out1_ready,
        output out1_data,
        output cnt0,
        output cnt1
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_sel,
        input  out0_valid,
        output out0_ready,
        input  out0_data,
        input  out1_valid,
        output out1_ready,
        input  out1_data,
        input  cnt0,
        input  cnt1
    );
endinterface

// File: rtl/stream_demux_1x2.sv
// ---------------------------------------------------------------------------
// stream_demux_1x2
//
// Registered 1-to-2 stream demultiplexer. Each accepted input beat is steered
// by in_sel into a one-entry holding register in front of out0 or out1, so
// the two consumers back-pressure independently. The beat appears on its
// output one cycle after acceptance. Per-output counters record how many beats
// have been accepted toward each destination.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  synchronous active-low reset; empties both slots, clears the data
//          registers and the counters, and forces in_ready low
//   bus    stream_demux_1x2_if.slave carrying the input stream, both output
//          streams and the two beat counters
// ---------------------------------------------------------------------------
module stream_demux_1x2 #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stream_demux_1x2_if.slave        bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      slot0_state;
    slot_state_t      slot0_next;
    slot_state_t      slot1_state;
    slot_state_t      slot1_next;

    logic [N-1:0]     slot0_data;
    logic [N-1:0]     slot1_data;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic             free0;
    logic             free1;
    logic             in_ready_int;
    logic             accept;
    logic             load0;
    logic             load1;

    // A slot can take a new beat when it is empty or when its consumer is
    // draining it this very cycle; the latter is what allows one beat per
    // cycle of sustained throughput to a single output.
    assign free0 = (slot0_state == EMPTY) || bus.out0_ready;
    assign free1 = (slot1_state == EMPTY) || bus.out1_ready;

    // Readiness looks only at the selected slot and never at in_valid, so the
    // producer may legally wait for ready before raising valid. Holding it low
    // during reset keeps the producer from believing a beat was taken.
    assign in_ready_int = rst_n && (bus.in_sel ? free1 : free0);
    assign accept       = bus.in_valid && in_ready_int;
    assign load0        = accept && !bus.in_sel;
    assign load1        = accept &&  bus.in_sel;

    // Slot occupancy registers. Reset discards whatever was buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot0_state <= EMPTY;
            slot1_state <= EMPTY;
        end else begin
            slot0_state <= slot0_next;
            slot1_state <= slot1_next;
        end
    end

    // Occupancy next-state: a load always leaves the slot FULL (covering the
    // simultaneous drain-and-refill case); otherwise a FULL slot empties only
    // when its consumer is ready.
    always_comb begin
        slot0_next = slot0_state;
        slot1_next = slot1_state;

        if (load0) begin
            slot0_next = FULL;
        end else if ((slot0_state == FULL) && bus.out0_ready) begin
            slot0_next = EMPTY;
        end

        if (load1) begin
            slot1_next = FULL;
        end else if ((slot1_state == FULL) && bus.out1_ready) begin
            slot1_next = EMPTY;
        end
    end

    // Payload registers only change on a load, which keeps the output data
    // stable for as long as a stalled consumer holds ready low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot0_data <= '0;
            slot1_data <= '0;
        end else begin
            if (load0) begin
                slot0_data <= bus.in_data;
            end
            if (load1) begin
                slot1_data <= bus.in_data;
            end
        end
    end

    // Debug counters track accepted beats (not drained ones) and wrap freely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (load0) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (load1) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    // All output-side signals come straight from registers; there is no
    // combinational path from in_data to either output.
    assign bus.in_ready   = in_ready_int;
    assign bus.out0_valid = (slot0_state == FULL);
    assign bus.out0_data  = slot0_data;
    assign bus.out1_valid = (slot1_state == FULL);
    assign bus.out1_data  = slot1_data;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;

endmodule

// File: tb/tb_stream_demux_1x2.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1x2
//
// Directed self-checking bench for stream_demux_1x2. Inputs are driven just
// after a rising edge and outputs are compared before the next one, against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_stream_demux_1x2;

    localparam int N     = 8;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;

    int   total_count;
    int   pass_count;
    int   fail_count;

    stream_demux_1x2_if #(.N(N), .CNT_W(CNT_W)) bus ();

    stream_demux_1x2 #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every input of the stream interface, then let combinational
    // outputs settle.
    task automatic apply_stimulus(input logic valid, input logic [N-1:0] data,
                                  input logic sel, input logic rdy0,
                                  input logic rdy1);
        bus.in_valid   = valid;
        bus.in_data    = data;
        bus.in_sel     = sel;
        bus.out0_ready = rdy0;
        bus.out1_ready = rdy1;
        #1;
    endtask

    // One comparison: counted, and reported on mismatch.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total_count = 0;
        pass_count  = 0;
        fail_count  = 0;

        // Reset held for two cycles with a beat offered.
        rst_n = 1'b0;
        apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);
        check_output("rst_in_ready_comb", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_output("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        check_output("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        check_output("rst_cnt0", 32'(bus.cnt0), 32'd0);
        check_output("rst_cnt1", 32'(bus.cnt1), 32'd0);

        // Basic steering: AA to out0, then 55 to out1.
        rst_n = 1'b1;
        apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);
        check_output("steer_in_ready0", 32'(bus.in_ready), 32'd1);
        check_output("steer_out0_not_yet", 32'(bus.out0_valid), 32'd0);
        tick();
        check_output("steer_out0_valid", 32'(bus.out0_valid), 32'd1);
        check_output("steer_out0_data", 32'(bus.out0_data), 32'hAA);
        check_output("steer_cnt0", 32'(bus.cnt0), 32'd1);
        apply_stimulus(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
        check_output("steer_in_ready1", 32'(bus.in_ready), 32'd1);
        tick();
        check_output("steer_out1_valid", 32'(bus.out1_valid), 32'd1);
        check_output("steer_out1_data", 32'(bus.out1_data), 32'h55);
        check_output("steer_out0_drained", 32'(bus.out0_valid), 32'd0);
        check_output("steer_cnt0_end", 32'(bus.cnt0), 32'd1);
        check_output("steer_cnt1_end", 32'(bus.cnt1), 32'd1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("steer_out1_drained", 32'(bus.out1_valid), 32'd0);

        // Back-pressure on out0: F0 is buffered, 0F waits upstream.
        apply_stimulus(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
        check_output("bp_in_ready_first", 32'(bus.in_ready), 32'd1);
        tick();
        check_output("bp_out0_valid", 32'(bus.out0_valid), 32'd1);
        check_output("bp_out0_data", 32'(bus.out0_data), 32'hF0);
        apply_stimulus(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1);
        check_output("bp_in_ready_second", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("bp_hold_data", 32'(bus.out0_data), 32'hF0);
            check_output("bp_hold_valid", 32'(bus.out0_valid), 32'd1);
            check_output("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        check_output("bp_cnt0_stalled", 32'(bus.cnt0), 32'd2);
        apply_stimulus(1'b1, 8'h0F, 1'b0, 1'b1, 1'b1);
        check_output("bp_in_ready_release", 32'(bus.in_ready), 32'd1);
        tick();
        check_output("bp_refill_valid", 32'(bus.out0_valid), 32'd1);
        check_output("bp_refill_data", 32'(bus.out0_data), 32'h0F);
        check_output("bp_cnt0", 32'(bus.cnt0), 32'd3);

        // Independence: out0 stalled and full with 0F, beat 3C goes to out1.
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_output("ind_sel0_blocked", 32'(bus.in_ready), 32'd0);
        tick();
        apply_stimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        check_output("ind_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_output("ind_out1_valid", 32'(bus.out1_valid), 32'd1);
        check_output("ind_out1_data", 32'(bus.out1_data), 32'h3C);
        check_output("ind_out0_valid", 32'(bus.out0_valid), 32'd1);
        check_output("ind_out0_data", 32'(bus.out0_data), 32'h0F);
        check_output("ind_cnt0", 32'(bus.cnt0), 32'd3);
        check_output("ind_cnt1", 32'(bus.cnt1), 32'd2);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("ind_out0_empty", 32'(bus.out0_valid), 32'd0);
        check_output("ind_out1_empty", 32'(bus.out1_valid), 32'd0);

        // Streaming: 16 back-to-back beats to out0, one cycle of latency each.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 8'(i), 1'b0, 1'b1, 1'b1);
            check_output("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            check_output("stream_out0_valid", 32'(bus.out0_valid), 32'd1);
            check_output("stream_out0_data", 32'(bus.out0_data), 32'(i));
        end
        // Three beats went to out0 earlier, plus these sixteen.
        check_output("stream_cnt0", 32'(bus.cnt0), 32'd19);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();

        // Reset while out1 holds 77 and is stalled.
        apply_stimulus(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        check_output("mid_out1_full", 32'(bus.out1_valid), 32'd1);
        check_output("mid_out1_data", 32'(bus.out1_data), 32'h77);
        rst_n = 1'b0;
        #1;
        check_output("mid_in_ready_rst", 32'(bus.in_ready), 32'd0);
        tick();
        check_output("mid_out1_dropped", 32'(bus.out1_valid), 32'd0);
        check_output("mid_out1_data_clr", 32'(bus.out1_data), 32'd0);
        check_output("mid_cnt0_clr", 32'(bus.cnt0), 32'd0);
        check_output("mid_cnt1_clr", 32'(bus.cnt1), 32'd0);
        rst_n = 1'b1;

        // Counter wrap: 256 accepted beats to out1.
        for (int i = 0; i < 255; i++) begin
            apply_stimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
            tick();
        end
        check_output("wrap_cnt1_255", 32'(bus.cnt1), 32'd255);
        check_output("wrap_out1_data_fe", 32'(bus.out1_data), 32'hFE);
        apply_stimulus(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        tick();
        check_output("wrap_cnt1_0", 32'(bus.cnt1), 32'd0);
        check_output("wrap_out1_data_ff", 32'(bus.out1_data), 32'hFF);
        check_output("wrap_cnt0_idle", 32'(bus.cnt0), 32'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
